mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Arbitrates the single shared RAM port between the instruction-cache request channel and the data-cache request channel.
- Sits between the cache controllers and the RAM model. The RAM model reports progress through the 2-bit ramstate encoding: FREE=0, BUSY=1, ACCESS=2, ERROR=3.
- One transaction is in flight at a time. Grants are registered, and a grant is held until the RAM reports ACCESS or the requester aborts.
- Keeps a saturating count of RAM ERROR cycles for debug.

Parameters:
- WORD_W, 32: address and data width.
- ERRCNT_W, 8: width of the error counter.

Ports:
- CLK  in  1  clock. Single clock domain.
- nRST  in  1  asynchronous, active-low reset.
- iREN  in  1  icache read request.
- iaddr  in  WORD_W  icache address.
- iwait  out  1  icache stall.
- iload  out  WORD_W  icache read data.
- dREN  in  1  dcache read request.
- dWEN  in  1  dcache write request.
- daddr  in  WORD_W  dcache address.
- dstore  in  WORD_W  dcache write data.
- dwait  out  1  dcache stall.
- dload  out  WORD_W  dcache read data.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  WORD_W  RAM address.
- ramstore  out  WORD_W  RAM write data.
- ramload  in  WORD_W  RAM read data.
- ramstate  in  2  RAM status.
- err_cnt  out  ERRCNT_W  saturating count of ERROR cycles.

Behaviour:
- States: IDLE, SERVE_I, SERVE_D. All state is registered. Reset forces IDLE, err_cnt=0 and last_grant=I.
- Reset, including mid-transaction: the state returns to IDLE asynchronously, so all RAM outputs drop to 0 immediately.
- IDLE:
  - ramREN, ramWEN, ramaddr and ramstore are all 0.
  - iwait=iREN; dwait=dREN|dWEN.
  - iload=0, dload=0.
- IDLE transitions at the next edge:
  - If dREN|dWEN, go to SERVE_D.
  - Else if iREN, go to SERVE_I.
  - Else stay in IDLE.
  - Fixed priority: dcache wins ties.
- SERVE_D:
  - RAM outputs are driven combinationally from the dcache inputs: ramaddr=daddr, ramstore=dstore.
  - If dWEN=1: ramWEN=1, ramREN=0. dWEN overrides dREN when both are set.
  - Else: ramREN=dREN, ramWEN=0.
  - iwait=iREN; iload=0.
- SERVE_I:
  - ramREN=iREN, ramaddr=iaddr, ramWEN=0, ramstore=0.
  - dwait=dREN|dWEN; dload=0.
- Completion: in SERVE_x with ramstate==ACCESS:
  - The granted wait drops to 0 in the same cycle.
  - The granted load output equals ramload (forced to 0 on writes).
  - Next state is IDLE and last_grant records x.
  - Minimum transaction time: one arbitration cycle plus one ACCESS cycle. At least one IDLE cycle separates back-to-back grants.
- FREE/BUSY in SERVE_x: hold the state; the granted wait stays 1.
- ERROR in SERVE_x:
  - Hold the state and keep the granted wait at 1; the RAM retries.
  - err_cnt increments by 1 per ERROR cycle and saturates at 2^ERRCNT_W-1.
  - ERROR cycles in IDLE are not counted.
- Abort: if the granted requester deasserts all of its enables in SERVE_x before ACCESS:
  - RAM enables drop in the same cycle, since they are combinational from the request.
  - Next state is IDLE; no completion is recorded and last_grant is unchanged.
- Data inputs (iaddr, daddr, dstore) are not latched; requesters must hold them stable until their wait drops.
- Addresses are passed through unmodified; there is no alignment check.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined:
  - In IDLE, a tie goes to the requester that is not last_grant. This gives round-robin between I and D.
  - After reset, last_grant=I, so D wins the first tie.
  - Without a tie, the single pending requester is granted.
- Undefined:
  - Fixed dcache priority. The icache can starve while the dcache requests continuously.
  - The last_grant register is still present but does not affect arbitration.

Test Plan:
- Single read: dREN=1, daddr=0x40; ramstate BUSY for cycles 1-2, ACCESS on cycle 3 with ramload=0xDEADBEEF.
  - Required: SERVE_D from cycle 1; ramREN=1 and ramaddr=0x40 on cycles 1-3.
  - Required: dwait=0 and dload=0xDEADBEEF on cycle 3 only; ramREN=0 on cycle 4.
- Contention: iREN (iaddr 0x100) and dWEN (daddr 0x200, dstore 0x12345678) held continuously; RAM answers ACCESS after 1 BUSY cycle.
  - Macro off: grant order is D,D,D and iwait stays 1.
  - MEM_ARB_RR_EN: grant order is D,I,D,I.
- Error path: in SERVE_I, drive ramstate ERROR for 3 cycles, then ACCESS.
  - Required: err_cnt=3; iwait=1 until the ACCESS cycle.
  - Required: 300 ERROR cycles with ERRCNT_W=8 give err_cnt=255.
- Abort: in SERVE_I with ramstate=BUSY, deassert iREN.
  - Required: ramREN=0 in the same cycle; IDLE at the next edge; err_cnt unchanged.
- Async reset mid-transfer: pull nRST low between edges while in SERVE_D with ramWEN=1.
  - Required: ramWEN=0 and err_cnt=0 immediately.
  - Required: after release, dREN starts a fresh grant one cycle later.
- Write override: dREN=dWEN=1, ACCESS on cycle 2.
  - Required: ramWEN=1, ramREN=0; dload=0 on completion.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates one shared RAM port between the icache and dcache
// request channels. One transaction is in flight at a time; the grant is held
// until the RAM reports ACCESS or the granted requester drops its enables.
// A saturating counter records RAM ERROR cycles seen while a grant is held.
//
// Optional feature (macro MEM_ARB_RR_EN): when defined, an IDLE tie goes to the
// requester that was not granted last (round-robin). When undefined, dcache has
// fixed priority.
//
// Ports:
//   CLK, nRST            clock, asynchronous active-low reset
//   iREN, iaddr          icache read request and address
//   iwait, iload         icache stall and read data
//   dREN, dWEN           dcache read / write request
//   daddr, dstore        dcache address and write data
//   dwait, dload         dcache stall and read data
//   ramREN, ramWEN       RAM read / write enable
//   ramaddr, ramstore    RAM address and write data
//   ramload, ramstate    RAM read data and status (FREE/BUSY/ACCESS/ERROR)
//   err_cnt              saturating count of ERROR cycles under a grant
module mem_arbiter #(
    parameter int unsigned WORD_W   = 32,
    parameter int unsigned ERRCNT_W = 8
) (
    input  logic                CLK,
    input  logic                nRST,
    input  logic                iREN,
    input  logic [WORD_W-1:0]   iaddr,
    output logic                iwait,
    output logic [WORD_W-1:0]   iload,
    input  logic                dREN,
    input  logic                dWEN,
    input  logic [WORD_W-1:0]   daddr,
    input  logic [WORD_W-1:0]   dstore,
    output logic                dwait,
    output logic [WORD_W-1:0]   dload,
    output logic                ramREN,
    output logic                ramWEN,
    output logic [WORD_W-1:0]   ramaddr,
    output logic [WORD_W-1:0]   ramstore,
    input  logic [WORD_W-1:0]   ramload,
    input  logic [1:0]          ramstate,
    output logic [ERRCNT_W-1:0] err_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    localparam logic [ERRCNT_W-1:0] ERR_MAX = {ERRCNT_W{1'b1}};

`ifdef MEM_ARB_RR_EN
    localparam logic RR_EN = 1'b1;
`else
    localparam logic RR_EN = 1'b0;
`endif

    state_t state, next_state;
    logic   last_grant;
    logic   i_req, d_req, access, error;

    // Request and RAM status decode.
    always_comb begin
        i_req  = iREN;
        d_req  = dREN | dWEN;
        access = (ramstate == RAM_ACCESS);
        error  = (ramstate == RAM_ERROR);
    end

    // State register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= IDLE;
        else       state <= next_state;
    end

    // Next-state logic; a completion or an abort both return to IDLE.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (d_req && i_req) begin
                    // Tie: round-robin against last_grant when enabled.
                    next_state = (RR_EN && (last_grant == GRANT_D)) ? SERVE_I : SERVE_D;
                end else if (d_req) begin
                    next_state = SERVE_D;
                end else if (i_req) begin
                    next_state = SERVE_I;
                end
            end
            SERVE_I: if (!i_req || access) next_state = IDLE;
            SERVE_D: if (!d_req || access) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output logic: RAM side is combinational from the granted request.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = i_req;
        dwait    = d_req;
        iload    = '0;
        dload    = '0;
        case (state)
            SERVE_I: begin
                ramREN  = iREN;
                ramaddr = iaddr;
                iwait   = i_req & ~access;
                if (i_req && access) iload = ramload;
            end
            SERVE_D: begin
                // Write wins when both dcache enables are set.
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
                dwait    = d_req & ~access;
                if (d_req && access && !dWEN) dload = ramload;
            end
            default: ;
        endcase
    end

    // Remember the last completed grant; aborts leave it unchanged.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            last_grant <= GRANT_I;
        end else if (state == SERVE_I && i_req && access) begin
            last_grant <= GRANT_I;
        end else if (state == SERVE_D && d_req && access) begin
            last_grant <= GRANT_D;
        end
    end

    // Saturating ERROR counter; only cycles under a grant are counted.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            err_cnt <= '0;
        end else if (state != IDLE && error && err_cnt != ERR_MAX) begin
            err_cnt <= err_cnt + ERRCNT_W'(1);
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed testbench for mem_arbiter. Inputs change just after
// the falling edge and outputs are sampled 1 time unit later, well away from
// the rising edge that advances the arbiter.
module tb_mem_arbiter;

    localparam logic [1:0] FREE   = 2'd0;
    localparam logic [1:0] BUSY   = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] ERROR  = 2'd3;

    logic        CLK, nRST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [1:0]  ramstate;
    logic        iwait, dwait, ramREN, ramWEN;
    logic [31:0] iload, dload, ramaddr, ramstore;
    logic [7:0]  err_cnt;

    int checks = 0;
    int passes = 0;

    mem_arbiter #(.WORD_W(32), .ERRCNT_W(8)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .err_cnt(err_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic cyc();
        @(negedge CLK);
    endtask

    task automatic clear_inputs();
        iREN = 0; dREN = 0; dWEN = 0;
        iaddr = 0; daddr = 0; dstore = 0;
        ramload = 0; ramstate = FREE;
    endtask

    // Reset for two cycles; returns at a falling edge with the arbiter in IDLE.
    task automatic do_reset();
        @(negedge CLK);
        nRST = 0;
        clear_inputs();
        cyc();
        cyc();
        nRST = 1;
    endtask

    // Drop all requests and let any grant unwind back to IDLE.
    task automatic go_idle();
        cyc();
        clear_inputs();
        cyc();
        cyc();
    endtask

    task automatic test_reset();
        @(negedge CLK);
        nRST = 0;
        clear_inputs();
        iREN = 1; dREN = 1; iaddr = 32'h1234; daddr = 32'h5678;
        cyc();
        #1;
        checks++; if ({ramREN, ramWEN} !== 2'b00) $display("FAIL reset_en: got %b want 00", {ramREN, ramWEN}); else passes++;
        checks++; if (ramaddr !== 32'h0) $display("FAIL reset_addr: got %h want 0", ramaddr); else passes++;
        checks++; if (err_cnt !== 8'd0) $display("FAIL reset_errcnt: got %0d want 0", err_cnt); else passes++;
        checks++; if ({iwait, dwait} !== 2'b11) $display("FAIL reset_wait: got %b want 11", {iwait, dwait}); else passes++;
        checks++; if ({iload, dload} !== 64'h0) $display("FAIL reset_load: got %h want 0", {iload, dload}); else passes++;
        cyc();
        clear_inputs();
        nRST = 1;
    endtask

    task automatic test_single_read();
        do_reset();
        dREN = 1; daddr = 32'h40;
        #1;
        checks++; if ({ramREN, dwait} !== 2'b01) $display("FAIL rd_c0: got ren,dwait=%b want 01", {ramREN, dwait}); else passes++;
        for (int c = 1; c <= 3; c++) begin
            cyc();
            ramstate = (c == 3) ? ACCESS : BUSY;
            ramload  = (c == 3) ? 32'hDEADBEEF : 32'h0;
            #1;
            checks++; if (ramREN !== 1'b1) $display("FAIL rd_ren c%0d: got %b want 1", c, ramREN); else passes++;
            checks++; if (ramaddr !== 32'h40) $display("FAIL rd_addr c%0d: got %h want 40", c, ramaddr); else passes++;
            checks++; if (dwait !== (c == 3 ? 1'b0 : 1'b1)) $display("FAIL rd_dwait c%0d: got %b want %b", c, dwait, (c != 3)); else passes++;
            checks++; if (dload !== (c == 3 ? 32'hDEADBEEF : 32'h0)) $display("FAIL rd_dload c%0d: got %h", c, dload); else passes++;
        end
        cyc();
        ramstate = FREE; ramload = 32'h0;
        #1;
        checks++; if ({ramREN, dwait} !== 2'b01) $display("FAIL rd_c4: got ren,dwait=%b want 01", {ramREN, dwait}); else passes++;
        go_idle();
    endtask

    task automatic test_contention();
        bit order_d [4];
        bit g_d;
        int ph;
`ifdef MEM_ARB_RR_EN
        order_d[0] = 1; order_d[1] = 0; order_d[2] = 1; order_d[3] = 0;
`else
        order_d[0] = 1; order_d[1] = 1; order_d[2] = 1; order_d[3] = 1;
`endif
        do_reset();
        iREN = 1; iaddr = 32'h100;
        dWEN = 1; daddr = 32'h200; dstore = 32'h12345678;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) cyc();
            ph = c % 3;
            g_d = order_d[c / 3];
            ramstate = (ph == 0) ? FREE : ((ph == 1) ? BUSY : ACCESS);
            ramload  = 32'hA0000000 + 32'(c);
            #1;
            if (ph == 0) begin
                checks++; if ({ramREN, ramWEN, iwait, dwait} !== 4'b0011) $display("FAIL ct_idle c%0d: got %b want 0011", c, {ramREN, ramWEN, iwait, dwait}); else passes++;
            end else if (ph == 1) begin
                if (g_d) begin
                    checks++; if ({ramREN, ramWEN} !== 2'b01) $display("FAIL ct_den c%0d: got %b want 01", c, {ramREN, ramWEN}); else passes++;
                    checks++; if ({ramaddr, ramstore} !== {32'h200, 32'h12345678}) $display("FAIL ct_dbus c%0d: got %h/%h", c, ramaddr, ramstore); else passes++;
                end else begin
                    checks++; if ({ramREN, ramWEN} !== 2'b10) $display("FAIL ct_ien c%0d: got %b want 10", c, {ramREN, ramWEN}); else passes++;
                    checks++; if ({ramaddr, ramstore} !== {32'h100, 32'h0}) $display("FAIL ct_ibus c%0d: got %h/%h", c, ramaddr, ramstore); else passes++;
                end
                checks++; if ({iwait, dwait} !== 2'b11) $display("FAIL ct_busy c%0d: got %b want 11", c, {iwait, dwait}); else passes++;
            end else begin
                if (g_d) begin
                    checks++; if ({iwait, dwait} !== 2'b10) $display("FAIL ct_dacc c%0d: got %b want 10", c, {iwait, dwait}); else passes++;
                    checks++; if (dload !== 32'h0) $display("FAIL ct_dload c%0d: got %h want 0", c, dload); else passes++;
                end else begin
                    checks++; if ({iwait, dwait} !== 2'b01) $display("FAIL ct_iacc c%0d: got %b want 01", c, {iwait, dwait}); else passes++;
                    checks++; if (iload !== 32'hA0000000 + 32'(c)) $display("FAIL ct_iload c%0d: got %h", c, iload); else passes++;
                end
            end
        end
        go_idle();
    endtask

    task automatic test_error();
        do_reset();
        iREN = 1; iaddr = 32'h300; ramstate = ERROR;
        #1;
        checks++; if ({iwait, ramREN} !== 2'b10) $display("FAIL er_c0: got %b want 10", {iwait, ramREN}); else passes++;
        for (int c = 1; c <= 3; c++) begin
            cyc();
            ramstate = ERROR;
            #1;
            checks++; if ({iwait, ramREN} !== 2'b11) $display("FAIL er_hold c%0d: got %b want 11", c, {iwait, ramREN}); else passes++;
            checks++; if (err_cnt !== 8'(c - 1)) $display("FAIL er_cnt c%0d: got %0d want %0d", c, err_cnt, c - 1); else passes++;
        end
        cyc();
        ramstate = ACCESS; ramload = 32'h11;
        #1;
        checks++; if ({iwait, iload} !== {1'b0, 32'h11}) $display("FAIL er_acc: got %b/%h want 0/11", iwait, iload); else passes++;
        checks++; if (err_cnt !== 8'd3) $display("FAIL er_cnt3: got %0d want 3", err_cnt); else passes++;
        // ERROR while IDLE must not count.
        cyc();
        iREN = 0; ramstate = ERROR;
        cyc();
        #1;
        checks++; if (err_cnt !== 8'd3) $display("FAIL er_idle: got %0d want 3", err_cnt); else passes++;
        iREN = 1; ramstate = FREE;
        cyc();
        for (int k = 0; k < 300; k++) begin
            ramstate = ERROR;
            cyc();
        end
        ramstate = ACCESS;
        #1;
        checks++; if (err_cnt !== 8'd255) $display("FAIL er_sat: got %0d want 255", err_cnt); else passes++;
        checks++; if (iwait !== 1'b0) $display("FAIL er_sat_acc: got %b want 0", iwait); else passes++;
        go_idle();
    endtask

    task automatic test_abort();
        do_reset();
        iREN = 1; iaddr = 32'h500;
        cyc();
        ramstate = ERROR;
        #1;
        checks++; if (ramREN !== 1'b1) $display("FAIL ab_grant: got %b want 1", ramREN); else passes++;
        cyc();
        ramstate = BUSY; iREN = 0;
        #1;
        checks++; if (ramREN !== 1'b0) $display("FAIL ab_ren: got %b want 0", ramREN); else passes++;
        checks++; if (err_cnt !== 8'd1) $display("FAIL ab_cnt: got %0d want 1", err_cnt); else passes++;
        cyc();
        iREN = 1;
        #1;
        checks++; if ({ramREN, iwait} !== 2'b01) $display("FAIL ab_idle: got %b want 01", {ramREN, iwait}); else passes++;
        checks++; if (err_cnt !== 8'd1) $display("FAIL ab_cnt2: got %0d want 1", err_cnt); else passes++;
        go_idle();
    endtask

    task automatic test_async_reset();
        do_reset();
        dWEN = 1; daddr = 32'h600; dstore = 32'h77;
        cyc();
        ramstate = ERROR;
        cyc();
        ramstate = BUSY;
        #1;
        checks++; if (ramWEN !== 1'b1) $display("FAIL ar_pre: got %b want 1", ramWEN); else passes++;
        checks++; if (err_cnt !== 8'd1) $display("FAIL ar_precnt: got %0d want 1", err_cnt); else passes++;
        #1;
        nRST = 0;
        #1;
        checks++; if ({ramWEN, ramaddr} !== {1'b0, 32'h0}) $display("FAIL ar_drop: got %b/%h want 0/0", ramWEN, ramaddr); else passes++;
        checks++; if (err_cnt !== 8'd0) $display("FAIL ar_cnt: got %0d want 0", err_cnt); else passes++;
        cyc();
        nRST = 1; dWEN = 0; dREN = 1; daddr = 32'h700; ramstate = BUSY;
        #1;
        checks++; if ({ramREN, dwait} !== 2'b01) $display("FAIL ar_idle: got %b want 01", {ramREN, dwait}); else passes++;
        cyc();
        #1;
        checks++; if ({ramREN, ramWEN, ramaddr} !== {2'b10, 32'h700}) $display("FAIL ar_regrant: got %b%b/%h want 10/700", ramREN, ramWEN, ramaddr); else passes++;
        go_idle();
    endtask

    task automatic test_write_override();
        do_reset();
        dREN = 1; dWEN = 1; daddr = 32'h80; dstore = 32'hCAFEF00D;
        #1;
        checks++; if (ramWEN !== 1'b0) $display("FAIL wo_idle: got %b want 0", ramWEN); else passes++;
        cyc();
        ramstate = BUSY;
        #1;
        checks++; if ({ramREN, ramWEN, dwait} !== 3'b011) $display("FAIL wo_en: got %b want 011", {ramREN, ramWEN, dwait}); else passes++;
        checks++; if (ramstore !== 32'hCAFEF00D) $display("FAIL wo_store: got %h want cafef00d", ramstore); else passes++;
        cyc();
        ramstate = ACCESS; ramload = 32'hFFFFFFFF;
        #1;
        checks++; if ({dwait, dload} !== {1'b0, 32'h0}) $display("FAIL wo_done: got %b/%h want 0/0", dwait, dload); else passes++;
        checks++; if (ramWEN !== 1'b1) $display("FAIL wo_wen: got %b want 1", ramWEN); else passes++;
        go_idle();
    endtask

    initial begin
        nRST = 1;
        clear_inputs();
        test_reset();
        test_single_read();
        test_contention();
        test_error();
        test_abort();
        test_async_reset();
        test_write_override();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
